// File: rtl/alarm_clock_controller.sv
// Alarm clock sequencer: time-of-day and alarm registers, mode/set FSM and ring control.
// All state advances on clk; tick_1hz and the button inputs are single-cycle enables.
module alarm_clock_controller #(
    parameter int unsigned ALARM_H_RST = 7,
    parameter int unsigned ALARM_M_RST = 0,
    parameter int unsigned RING_SECS   = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz_i,
    input  logic       btn_mode_i,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    input  logic       alarm_off_i,
    output logic [4:0] hours_o,
    output logic [5:0] minutes_o,
    output logic [5:0] seconds_o,
    output logic [4:0] alarm_h_o,
    output logic [5:0] alarm_m_o,
    output logic [2:0] mode_o,
    output logic       alarm_en_o,
    output logic       ringing_o
);

    // state  | meaning
    // RUN    | clock runs, btn_down arms/disarms the alarm
    // SET_TH | edit time hours, clock frozen
    // SET_TM | edit time minutes, clock frozen, seconds cleared on exit
    // SET_AH | edit alarm hour, clock runs
    // SET_AM | edit alarm minute, clock runs
    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_TH = 3'd1,
        SET_TM = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4
    } mode_e;

    mode_e      mode_q, mode_d;
    logic [4:0] hours_q, hours_d, alarm_h_q, alarm_h_d;
    logic [5:0] minutes_q, minutes_d, seconds_q, seconds_d, alarm_m_q, alarm_m_d;
    logic       alarm_en_q, alarm_en_d, ringing_q, ringing_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic       time_runs, edit_up, edit_dn, any_btn;

    function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max_v,
                                             input logic up);
        if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? max_v : v - 6'd1;
    endfunction

    always_comb begin
        mode_d     = mode_q;
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        alarm_h_d  = alarm_h_q;
        alarm_m_d  = alarm_m_q;
        alarm_en_d = alarm_en_q;
        ringing_d  = ringing_q;
        ring_cnt_d = ring_cnt_q;

        time_runs = tick_1hz_i && (mode_q == RUN || mode_q == SET_AH || mode_q == SET_AM);
        edit_up   = btn_up_i & ~btn_down_i;
        edit_dn   = btn_down_i & ~btn_up_i;
        any_btn   = btn_mode_i | btn_up_i | btn_down_i | alarm_off_i;

        if (time_runs) begin
            seconds_d = step_wrap(seconds_q, 6'd59, 1'b1);
            if (seconds_q == 6'd59) begin
                minutes_d = step_wrap(minutes_q, 6'd59, 1'b1);
                if (minutes_q == 6'd59)
                    hours_d = 5'(step_wrap({1'b0, hours_q}, 6'd23, 1'b1));
            end
        end

        if (ringing_q) begin
            // a button that silences the alarm is swallowed entirely
            if (any_btn) begin
                ringing_d = 1'b0;
            end else if (tick_1hz_i) begin
                if (ring_cnt_q == 8'(RING_SECS - 1)) ringing_d = 1'b0;
                else                                  ring_cnt_d = ring_cnt_q + 8'd1;
            end
        end else begin
            if (btn_mode_i) begin
                case (mode_q)
                    RUN:     mode_d = SET_TH;
                    SET_TH:  mode_d = SET_TM;
                    SET_TM:  mode_d = SET_AH;
                    SET_AH:  mode_d = SET_AM;
                    default: mode_d = RUN;
                endcase
                if (mode_q == SET_TM) seconds_d = 6'd0;
            end else if (edit_up || edit_dn) begin
                case (mode_q)
                    RUN:     if (edit_dn) alarm_en_d = ~alarm_en_q;
                    SET_TH:  hours_d   = 5'(step_wrap({1'b0, hours_q}, 6'd23, edit_up));
                    SET_TM:  minutes_d = step_wrap(minutes_q, 6'd59, edit_up);
                    SET_AH:  alarm_h_d = 5'(step_wrap({1'b0, alarm_h_q}, 6'd23, edit_up));
                    SET_AM:  alarm_m_d = step_wrap(alarm_m_q, 6'd59, edit_up);
                    default: ;
                endcase
            end
            // only the tick that lands exactly on hh:mm:00 can fire the alarm
            if (mode_q == RUN && alarm_en_q && tick_1hz_i && hours_d == alarm_h_q &&
                minutes_d == alarm_m_q && seconds_d == 6'd0) begin
                ringing_d  = 1'b1;
                ring_cnt_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= RUN;
            hours_q    <= 5'd0;
            minutes_q  <= 6'd0;
            seconds_q  <= 6'd0;
            alarm_h_q  <= 5'(ALARM_H_RST);
            alarm_m_q  <= 6'(ALARM_M_RST);
            alarm_en_q <= 1'b0;
            ringing_q  <= 1'b0;
            ring_cnt_q <= 8'd0;
        end else begin
            mode_q     <= mode_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            alarm_h_q  <= alarm_h_d;
            alarm_m_q  <= alarm_m_d;
            alarm_en_q <= alarm_en_d;
            ringing_q  <= ringing_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign hours_o    = hours_q;
    assign minutes_o  = minutes_q;
    assign seconds_o  = seconds_q;
    assign alarm_h_o  = alarm_h_q;
    assign alarm_m_o  = alarm_m_q;
    assign mode_o     = mode_q;
    assign alarm_en_o = alarm_en_q;
    assign ringing_o  = ringing_q;

endmodule

// File: tb/tb_alarm_clock_controller.sv
// Bench for alarm_clock_controller: vector table, directed corner sequences and
// random stimulus compared against a seconds-of-day reference model.
module tb_alarm_clock_controller;
    localparam int RS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, btn_mode, btn_up, btn_down, alarm_off;
    logic [4:0] hours, alarm_h;
    logic [5:0] minutes, seconds, alarm_m;
    logic [2:0] mode;
    logic       alarm_en, ringing;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state: time kept as seconds since midnight
    int t, md, ah, am, cnt;
    bit en, ring;

    alarm_clock_controller #(.ALARM_H_RST(7), .ALARM_M_RST(0), .RING_SECS(RS)) dut (
        .clk(clk), .rst(rst), .tick_1hz_i(tick_1hz), .btn_mode_i(btn_mode),
        .btn_up_i(btn_up), .btn_down_i(btn_down), .alarm_off_i(alarm_off),
        .hours_o(hours), .minutes_o(minutes), .seconds_o(seconds),
        .alarm_h_o(alarm_h), .alarm_m_o(alarm_m), .mode_o(mode),
        .alarm_en_o(alarm_en), .ringing_o(ringing)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit tk, m, u, d, o;
        int h, mi, s, ah, am, md;
        bit en, ring;
    } vec_t;
    vec_t tbl[21];

    function automatic logic [32:0] dut_vec();
        return {hours, minutes, seconds, alarm_h, alarm_m, mode, alarm_en, ringing};
    endfunction

    function automatic logic [32:0] model_vec();
        return {5'(t / 3600), 6'((t / 60) % 60), 6'(t % 60), 5'(ah), 6'(am), 3'(md), en, ring};
    endfunction

    function automatic logic [32:0] row_vec(input vec_t r);
        return {5'(r.h), 6'(r.mi), 6'(r.s), 5'(r.ah), 6'(r.am), 3'(r.md), r.en, r.ring};
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; md = 0; ah = 7; am = 0; en = 0; ring = 0; cnt = 0;
    endtask

    task automatic model_step(input bit tk, input bit m, input bit u, input bit d, input bit o);
        int tn, h, mi, dl;
        bit trig;
        tn = t;
        if (tk && (md == 0 || md == 3 || md == 4)) tn = (t + 1) % 86400;
        trig = (md == 0) && en && tk && (tn == ah * 3600 + am * 60);
        if (ring) begin
            if (m || u || d || o) ring = 0;
            else if (tk) begin
                if (cnt == RS - 1) ring = 0;
                else cnt++;
            end
        end else begin
            if (m) begin
                if (md == 2) tn = tn - tn % 60;
                md = (md + 1) % 5;
            end else if (u != d) begin
                dl = u ? 1 : -1;
                h  = tn / 3600;
                mi = (tn / 60) % 60;
                case (md)
                    0: if (d) en = !en;
                    1: tn = ((h + dl + 24) % 24) * 3600 + tn % 3600;
                    2: tn = h * 3600 + ((mi + dl + 60) % 60) * 60 + tn % 60;
                    3: ah = (ah + dl + 24) % 24;
                    default: am = (am + dl + 60) % 60;
                endcase
            end
            if (trig) begin ring = 1; cnt = 0; end
        end
        t = tn;
    endtask

    task automatic apply(input bit tk, input bit m, input bit u, input bit d, input bit o);
        tick_1hz = tk; btn_mode = m; btn_up = u; btn_down = d; alarm_off = o;
        @(posedge clk);
        model_step(tk, m, u, d, o);
        #1;
        tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0; alarm_off = 0;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0; alarm_off = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        check("reset", dut_vec(), {5'd0, 6'd0, 6'd0, 5'd7, 6'd0, 3'd0, 1'b0, 1'b0});
    endtask

    // leaves the clock at 06:59:00 in RUN with the 07:00 alarm armed
    task automatic arm_0659();
        do_reset();
        apply(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) apply(0, 0, 1, 0, 0);
        apply(0, 1, 0, 0, 0);
        apply(0, 0, 0, 1, 0);
        apply(0, 1, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        apply(0, 0, 0, 1, 0);
    endtask

    initial begin
        bit seen;
        //            tk m u d o   h  mi  s ah am md en ring
        tbl[0]  = '{1, 0, 0, 0, 0, 0,  0, 1, 7, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0,  0, 2, 7, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0,  0, 3, 7, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 0,  0, 3, 7, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 0, 23, 0, 3, 7, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 1, 0, 0, 0,  0, 3, 7, 0, 1, 0, 0};
        tbl[6]  = '{0, 0, 1, 1, 0, 0,  0, 3, 7, 0, 1, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, 0, 0,  0, 3, 7, 0, 1, 0, 0};
        tbl[8]  = '{0, 1, 1, 0, 0, 0,  0, 3, 7, 0, 2, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 0, 0, 59, 3, 7, 0, 2, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 59, 3, 7, 0, 2, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 0, 0, 59, 0, 7, 0, 3, 0, 0};
        tbl[12] = '{1, 0, 1, 0, 0, 0, 59, 1, 8, 0, 3, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 0, 0, 59, 1, 8, 0, 4, 0, 0};
        tbl[14] = '{0, 0, 0, 1, 0, 0, 59, 1, 8, 59, 4, 0, 0};
        tbl[15] = '{1, 0, 1, 0, 0, 0, 59, 2, 8, 0, 4, 0, 0};
        tbl[16] = '{0, 1, 0, 0, 0, 0, 59, 2, 8, 0, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 1, 0, 0, 59, 2, 8, 0, 0, 1, 0};
        tbl[18] = '{0, 0, 1, 0, 0, 0, 59, 2, 8, 0, 0, 1, 0};
        tbl[19] = '{0, 0, 1, 1, 0, 0, 59, 2, 8, 0, 0, 1, 0};
        tbl[20] = '{0, 0, 0, 1, 0, 0, 59, 2, 8, 0, 0, 0, 0};

        do_reset();
        foreach (tbl[i]) begin
            apply(tbl[i].tk, tbl[i].m, tbl[i].u, tbl[i].d, tbl[i].o);
            check($sformatf("table[%0d]", i), dut_vec(), row_vec(tbl[i]));
        end

        // frozen seconds in SET_TM, clear on exit, then midnight wrap
        do_reset();
        ticks(3);
        apply(0, 1, 0, 0, 0);
        apply(0, 0, 0, 1, 0);
        apply(0, 1, 0, 0, 0);
        apply(0, 0, 0, 1, 0);
        ticks(5);
        check("settm_frozen", 33'(seconds), 33'd3);
        apply(0, 1, 0, 0, 0);
        check("settm_exit_clear", 33'(seconds), 33'd0);
        apply(0, 1, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        ticks(58);
        check("at_235958", 33'({hours, minutes, seconds}), 33'({5'd23, 6'd59, 6'd58}));
        ticks(2);
        check("midnight_wrap", 33'({hours, minutes, seconds}), 33'd0);

        // trigger, hold for RS ticks, no retrigger in the same minute
        arm_0659();
        ticks(59);
        check("no_ring_early", 33'(ringing), 33'd0);
        ticks(1);
        check("ring_start", 33'({hours, minutes, seconds, ringing}), 33'({5'd7, 6'd0, 6'd0, 1'b1}));
        ticks(RS - 1);
        check("ring_hold", 33'(ringing), 33'd1);
        ticks(1);
        check("ring_end", 33'(ringing), 33'd0);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            apply(1, 0, 0, 0, 0);
            if (ringing) seen = 1;
        end
        check("no_retrigger", 33'(seen), 33'd0);

        // silencing buttons are consumed
        arm_0659();
        ticks(60);
        apply(0, 1, 0, 0, 0);
        check("silence_mode", 33'({mode, ringing}), 33'({3'd0, 1'b0}));
        arm_0659();
        ticks(60);
        apply(0, 0, 0, 0, 1);
        check("silence_off", 33'({mode, ringing}), 33'({3'd0, 1'b0}));
        arm_0659();
        ticks(61);
        apply(0, 0, 0, 1, 0);
        check("silence_down", 33'({alarm_en, ringing}), 33'({1'b1, 1'b0}));

        // asynchronous reset in the middle of an alarm-minute edit
        do_reset();
        for (int i = 0; i < 4; i++) apply(0, 1, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        apply(1, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1;
        #1;
        check("async_rst", dut_vec(), {5'd0, 6'd0, 6'd0, 5'd7, 6'd0, 3'd0, 1'b0, 1'b0});
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;

        // random stimulus against the model, starting armed near the alarm
        arm_0659();
        for (int i = 0; i < 4000; i++)
            apply(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
